prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Byte-stream boot loader that writes a program image into the program memory through its byte write port (we/addr/din).
- Sits between the UART receiver and the program memory.
- Holds the CPU in reset until a complete, checksum-verified image has been written.
- Frame format:
  - 4-byte little-endian length N.
  - N payload bytes, stored at addresses 0..N-1.
  - 1 checksum byte: sum of payload bytes mod 256.

Parameters:
- MEM_SIZE, 32767: highest program memory byte index; capacity is MEM_SIZE+1 bytes.
- ADDRW, $clog2(MEM_SIZE): address width (15 at default); derived, not overridden.
- TIMEOUT_CYCLES, 1000000: maximum idle cycles between accepted bytes while a frame is in progress.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a new load.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid; source holds it until accepted.
- rx_ready  out  1  loader can accept a byte this cycle.
- mem_we  out  1  program memory write enable (memory samples on falling edge).
- mem_addr  out  ADDRW  byte address for write.
- mem_din  out  32  write data; [7:0] = byte, [31:8] = 0.
- cpu_hold  out  1  keeps CPU in reset.
- busy  out  1  frame in progress.
- done  out  1  image loaded and verified.
- error  out  1  load failed.

Behaviour:
- Byte accept = rx_valid && rx_ready, sampled on rising edge.
- All outputs are registered, except rx_ready, which is combinational from state and mem_we.
- Reset values:
  - state = IDLE.
  - rx_ready = 0, mem_we = 0, mem_addr = 0, mem_din = 0.
  - cpu_hold = 1, busy = 0, done = 0, error = 0.
  - Counters and checksum = 0.
- States: IDLE, HDR, DATA, CSUM, DONE, ERROR.
- IDLE:
  - rx_ready = 0.
  - start -> HDR; clears byte counter, checksum and timeout counter.
- HDR:
  - rx_ready = 1, busy = 1.
  - Accepted bytes fill len[7:0], len[15:8], len[23:16], len[31:24] in that order.
  - After the 4th byte:
    - len == 0 or len > MEM_SIZE+1 -> ERROR.
    - Otherwise -> DATA with byte counter = 0.
- DATA:
  - rx_ready = !mem_we, so at most one byte accepted per 2 cycles.
  - Cycle after an accept:
    - mem_we = 1 for exactly one cycle.
    - mem_addr = counter value before increment.
    - mem_din = {24'b0, byte}.
  - Checksum += byte (8-bit wrap).
  - counter += 1.
  - When counter reaches len, state goes to CSUM on the same edge that raises mem_we for the last byte.
- CSUM:
  - rx_ready = 1.
  - On accept: byte == checksum -> DONE; otherwise -> ERROR.
- DONE: cpu_hold = 0, done = 1, busy = 0.
- ERROR: cpu_hold = 1, error = 1, busy = 0.
- Timeout:
  - In HDR/DATA/CSUM, the counter increments every cycle with no accept and clears on each accept.
  - Reaching TIMEOUT_CYCLES -> ERROR.
- start handling:
  - Ignored in HDR/DATA/CSUM.
  - In DONE or ERROR: -> HDR, clears done/error, sets cpu_hold = 1.
- Simultaneous start and rst: rst wins.
- rst mid-frame:
  - Returns to IDLE next edge; no further mem_we.
  - Bytes already written stay in memory.
  - cpu_hold = 1.
- Bytes arriving in IDLE/DONE/ERROR are not accepted (rx_ready = 0).
- len == MEM_SIZE+1: last write at mem_addr = MEM_SIZE; address never wraps.

Test Plan:
- Normal load:
  - Stimulus: start, then bytes 08 00 00 00, B7 10 00 00 93 80 80 00, 5A.
  - Required: exactly 8 mem_we pulses at addr 0..7 with din 0xB7, 0x10, 0x00, 0x00, 0x93, 0x80, 0x80, 0x00; then done = 1, cpu_hold = 0, error = 0.
  - Memory readback at addr 0 = 0x000010B7; at addr 4 = 0x00808093.
- Bad checksum: same frame with final byte 5B -> all 8 writes occur, then error = 1, cpu_hold = 1, done = 0.
- Length errors:
  - Header 00 00 00 00 -> ERROR after 4th byte, no mem_we.
  - Header 01 80 00 00 (32769) -> ERROR, no mem_we.
- Timeout: TIMEOUT_CYCLES = 100; start, send 08 00 00 00 B7, then rx_valid low -> error = 1 exactly 100 cycles after last accept; only 1 write.
- Backpressure and mid-frame reset:
  - rx_valid held high continuously in DATA -> rx_ready alternates 1/0; one write per 2 cycles.
  - rst after the 3rd payload byte -> IDLE, no further writes.
  - Then start plus a full valid frame -> done = 1.
- Restart from DONE: start while done = 1 -> done = 0, cpu_hold = 1, busy = 1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: byte-stream boot loader sitting between a UART receiver and the
// program memory. It parses a frame made of a 4-byte little-endian length, the
// payload and a one-byte additive checksum. Each payload byte is written into
// program memory, and the CPU is held in reset until the image has been verified.
module prog_loader #(
  parameter  int MEM_SIZE       = 32767,
  parameter  int TIMEOUT_CYCLES = 1000000,
  localparam int ADDRW          = $clog2(MEM_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [31:0]      mem_din,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // Largest accepted payload length: the whole memory, addresses 0..MEM_SIZE.
  localparam logic [31:0] MAX_LEN = 32'(MEM_SIZE) + 32'd1;

  // The idle counter holds values 0..TIMEOUT_CYCLES-1. Reaching the last value
  // on a cycle with no accepted byte ends the frame.
  localparam int           TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;      // header byte index, then payload byte index
  logic [31:0]      len_q, len_d;      // payload length, assembled LSB first
  logic [7:0]       csum_q, csum_d;    // running mod-256 sum of the payload
  logic [TW-1:0]    tmo_q, tmo_d;      // cycles since the last accepted byte

  logic             mem_we_q, mem_we_d;
  logic [ADDRW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]       din_q, din_d;
  logic             cpu_hold_q, cpu_hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             accept;
  logic             tmo_hit;
  logic [31:0]      hdr_len;
  logic [31:0]      cnt_inc;

  // Handshake: a header byte or the checksum byte may be taken on any cycle.
  // A payload byte is only taken while no write is in flight, which gives
  // at most one payload byte every two cycles.
  always_comb begin
    rx_ready = 1'b0;
    unique case (state_q)
      S_HDR, S_CSUM: rx_ready = 1'b1;
      S_DATA:        rx_ready = !mem_we_q;
      default:       rx_ready = 1'b0;
    endcase
  end

  assign accept  = rx_valid && rx_ready;
  assign tmo_hit = !accept && (tmo_q == TMO_LAST);
  // Length as it will look once the current byte is shifted in as the top byte.
  assign hdr_len = {rx_data, len_q[31:8]};
  assign cnt_inc = cnt_q + 32'd1;

  // State register: the FSM state, frame bookkeeping and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      din_q      <= '0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      din_q      <= din_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic: frame parsing, checksum accumulation and the idle timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        // A new load can begin from any of the resting states.
        if (start) begin
          state_d = S_HDR;
          cnt_d   = '0;
          len_d   = '0;
          csum_d  = '0;
          tmo_d   = '0;
        end
      end

      S_HDR: begin
        tmo_d = accept ? '0 : tmo_q + 1'b1;
        if (accept) begin
          len_d = hdr_len;
          if (cnt_q[1:0] == 2'd3) begin
            cnt_d = '0;
            if ((hdr_len == 32'd0) || (hdr_len > MAX_LEN)) begin
              state_d = S_ERROR;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (tmo_hit) begin
          state_d = S_ERROR;
        end
      end

      S_DATA: begin
        tmo_d = accept ? '0 : tmo_q + 1'b1;
        if (accept) begin
          csum_d = csum_q + rx_data;
          cnt_d  = cnt_inc;
          // Leave on the same edge that launches the write of the last byte.
          if (cnt_inc == len_q) begin
            state_d = S_CSUM;
          end
        end else if (tmo_hit) begin
          state_d = S_ERROR;
        end
      end

      S_CSUM: begin
        tmo_d = accept ? '0 : tmo_q + 1'b1;
        if (accept) begin
          state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
        end else if (tmo_hit) begin
          state_d = S_ERROR;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: the values the output registers take on the coming edge.
  always_comb begin
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    din_d      = din_q;
    // Each accepted payload byte becomes a one-cycle write. The address is the
    // byte index before the increment, so it never goes past MEM_SIZE.
    if ((state_q == S_DATA) && accept) begin
      mem_we_d   = 1'b1;
      mem_addr_d = cnt_q[ADDRW-1:0];
      din_d      = rx_data;
    end
    busy_d     = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERROR);
    cpu_hold_d = (state_d != S_DONE);
  end

  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = {24'b0, din_q};
  assign cpu_hold = cpu_hold_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized frames against a frame-level reference model.
// Expected memory writes and the final outcome of each frame are queued as the
// frame is issued. A monitor pops and compares each event as the DUT produces it.
module tb_prog_loader;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_din;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  prog_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Event kinds: 0 = memory write, 1 = load verified, 2 = load failed.
  typedef struct {
    int kind;
    int addr;
    int data;
  } ev_t;
  ev_t exp_q[$];

  logic [7:0] mem [0:32767];
  logic [7:0] frame_q[$];
  bit         mon_en = 1'b0;
  logic       done_prev = 1'b0;
  logic       err_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int addr, input int data);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Program memory model: latches the write on the falling edge.
  always @(negedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din[7:0];
  end

  // Monitor: compares every DUT event with the head of the expected queue.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %0h din %0h expected no write", mem_addr, mem_din);
        end else begin
          e = exp_q.pop_front();
          check("event_kind_write", 0, e.kind);
          check("write_addr", 32'(mem_addr), e.addr);
          check("write_din", mem_din, e.data);
        end
      end
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no event");
        end else begin
          e = exp_q.pop_front();
          check("event_kind_done", 1, e.kind);
          check("done_cpu_hold", cpu_hold, 0);
          check("done_error", error, 0);
        end
      end
      if (error && !err_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_error: got error=1 expected no event");
        end else begin
          e = exp_q.pop_front();
          check("event_kind_error", 2, e.kind);
          check("error_cpu_hold", cpu_hold, 1);
          check("error_done", done, 0);
        end
      end
    end
    done_prev = done;
    err_prev  = error;
  end

  // Reference model: derives the expected writes and the outcome from frame_q.
  // A frame that stops short is expected to end in a timeout error.
  task automatic model_frame(output int nsend, output int len_o);
    int n;
    int unsigned len;
    int sum;
    n = frame_q.size();
    len = {frame_q[3], frame_q[2], frame_q[1], frame_q[0]};
    sum = 0;
    len_o = 0;
    if (len == 0 || len > 32768) begin
      push_ev(2, 0, 0);
      nsend = 4;
    end else begin
      len_o = int'(len);
      for (int i = 0; i < int'(len) && 4 + i < n; i++) begin
        push_ev(0, i, int'(frame_q[4 + i]));
        sum += int'(frame_q[4 + i]);
      end
      if (n >= 5 + int'(len)) begin
        push_ev((int'(frame_q[4 + len]) == sum % 256) ? 1 : 2, 0, 0);
        nsend = 5 + int'(len);
      end else begin
        push_ev(2, 0, 0);
        nsend = n;
      end
    end
  endtask

  // Present one byte after an optional idle gap and wait until it is taken.
  // Start pulses can be sprinkled into the gap; the DUT must ignore them.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke, output int acc);
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) begin
        if (poke && $urandom_range(0, 3) == 0) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    acc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL byte_accept: got no accept of %0h expected accept within 50 cycles", b);
      rx_valid = 1'b0;
    end
  endtask

  task automatic wait_outcome(input int budget, output int oc);
    oc = -1;
    for (int k = 0; k < budget; k++) begin
      if (done || error) begin
        oc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (oc < 0) begin
      checks++; errors++;
      $display("FAIL outcome_wait: got neither done nor error expected one within %0d cycles", budget);
    end
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int maxgap, input bit poke, output int first_pay,
                           output int last_pay, output int last_acc, output int oc);
    int nsend, len, acc, gap;
    model_frame(nsend, len);
    first_pay = 0;
    last_pay  = 0;
    last_acc  = 0;
    for (int i = 0; i < nsend; i++) begin
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      send_byte(frame_q[i], gap, poke && i >= 1, acc);
      if (i == 4) first_pay = acc;
      if (len > 0 && i == 3 + len) last_pay = acc;
      last_acc = acc;
    end
    rx_valid = 1'b0;
    wait_outcome(300, oc);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int fp, lp, la, oc, acc, len, r;
    logic [31:0] lv;
    logic [7:0]  b;

    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_ready", rx_ready, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_addr", 32'(mem_addr), 0);
    check("reset_mem_din", mem_din, 0);
    check("reset_cpu_hold", cpu_hold, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Reference frame, with the source holding rx_valid high throughout.
    pulse_start();
    check("start_busy", busy, 1);
    frame_q = {8'h08, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h10, 8'h00, 8'h00,
               8'h93, 8'h80, 8'h80, 8'h00, 8'h5A};
    run_frame(0, 1'b0, fp, lp, la, oc);
    check("backpressure_spacing", 32'(lp - fp), 14);
    check("normal_done", done, 1);
    check("normal_cpu_hold", cpu_hold, 0);
    check("normal_error", error, 0);
    check("readback_addr0", {mem[3], mem[2], mem[1], mem[0]}, 32'h000010B7);
    check("readback_addr4", {mem[7], mem[6], mem[5], mem[4]}, 32'h00808093);

    // Bytes offered in DONE must not be taken.
    rx_valid = 1'b1; rx_data = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check("done_rx_ready", rx_ready, 0);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    check("done_holds", done, 1);

    // Restart from DONE.
    pulse_start();
    check("restart_done", done, 0);
    check("restart_cpu_hold", cpu_hold, 1);
    check("restart_busy", busy, 1);

    // Bad checksum.
    frame_q = {8'h08, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h10, 8'h00, 8'h00,
               8'h93, 8'h80, 8'h80, 8'h00, 8'h5B};
    run_frame(3, 1'b1, fp, lp, la, oc);
    check("badsum_error", error, 1);
    check("badsum_cpu_hold", cpu_hold, 1);
    check("badsum_done", done, 0);

    // Length errors.
    pulse_start();
    frame_q = {8'h00, 8'h00, 8'h00, 8'h00};
    run_frame(2, 1'b0, fp, lp, la, oc);
    check("len0_error", error, 1);
    pulse_start();
    frame_q = {8'h01, 8'h80, 8'h00, 8'h00};
    run_frame(2, 1'b0, fp, lp, la, oc);
    check("len32769_error", error, 1);

    // Timeout after the first payload byte.
    pulse_start();
    frame_q = {8'h08, 8'h00, 8'h00, 8'h00, 8'hB7};
    run_frame(0, 1'b0, fp, lp, la, oc);
    check("timeout_latency", 32'(oc - la), TMO);
    check("timeout_error", error, 1);

    // Reset after the third payload byte, with start raised at the same time.
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      b = (i == 0) ? 8'h08 : 8'h00;
      send_byte(b, 0, 1'b0, acc);
    end
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      push_ev(0, i, int'(b));
      send_byte(b, 0, 1'b0, acc);
    end
    rx_valid = 1'b0;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_cpu_hold", cpu_hold, 1);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_rx_ready", rx_ready, 0);
    repeat (10) @(posedge clk);
    #1;
    check("midrst_stays_idle", busy, 0);

    // Followed by a full valid frame.
    pulse_start();
    frame_q = {8'h05, 8'h00, 8'h00, 8'h00};
    r = 0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      r += int'(b);
    end
    frame_q.push_back(8'(r));
    run_frame(2, 1'b0, fp, lp, la, oc);
    check("after_rst_done", done, 1);

    // Randomized frames.
    for (int t = 0; t < 14; t++) begin
      pulse_start();
      frame_q = {};
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        lv = (($urandom_range(0, 1) == 0) ? 32'd0 : 32'd32769 + 32'($urandom_range(0, 5000)));
        for (int i = 0; i < 4; i++) frame_q.push_back(lv[8*i +: 8]);
      end else begin
        len = int'($urandom_range(1, 24));
        lv = 32'(len);
        for (int i = 0; i < 4; i++) frame_q.push_back(lv[8*i +: 8]);
        r = 0;
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          frame_q.push_back(b);
          r += int'(b);
        end
        if ($urandom_range(0, 9) < 7) frame_q.push_back(8'(r));
        else frame_q.push_back(8'(r + int'($urandom_range(1, 255))));
      end
      run_frame(4, 1'b1, fp, lp, la, oc);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
